// File: rtl/uart_frame_tx_if.sv
// Handshake and buffer read-port bundle between the frame transmitter and its system.
interface uart_frame_tx_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              start;
  logic              busy;
  logic              done;
  logic              tx;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;

  modport master (output start, output rd_data, input busy, input done, input tx, input rd_addr);
  modport slave  (input start, input rd_data, output busy, output done, output tx, output rd_addr);
endinterface

// File: rtl/uart_frame_tx.sv
// Framed 8N1 UART transmitter: 0xA5, 16-bit length, buffered payload, optional checksum.
// Define UART_FRAME_CHECKSUM_EN to append the mod-256 payload checksum byte.
module uart_frame_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FRAME_LEN    = 1024,
  parameter int unsigned ADDR_W       = 10
) (
  input  logic            clk,
  input  logic            rst,
  uart_frame_tx_if.slave  bus
);

  localparam int unsigned      BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [15:0]      LEN16     = 16'(FRAME_LEN);
  localparam logic [15:0]      CNT_LAST  = 16'(FRAME_LEN - 1);
  localparam logic [7:0]       SYNC_BYTE = 8'hA5;
  localparam logic [3:0]       STOP_BIT  = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_SYNC,
    S_HDR_LEN_HI,
    S_HDR_LEN_LO,
    S_PAYLOAD,
`ifdef UART_FRAME_CHECKSUM_EN
    S_CHECKSUM,
`endif
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [3:0]        bit_q, bit_d;
  logic [15:0]       byte_cnt_q, byte_cnt_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef UART_FRAME_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic bit_end_c;
  logic byte_end_c;

  assign bit_end_c  = (baud_q == BAUD_LAST);
  assign byte_end_c = bit_end_c && (bit_q == STOP_BIT);

  // Byte sequencing, bit timing and the registered line/handshake outputs.
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    byte_cnt_d = byte_cnt_q;
    tx_byte_d  = tx_byte_q;
    rd_addr_d  = rd_addr_q;
`ifdef UART_FRAME_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    tx_d       = 1'b1;
    busy_d     = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d   = S_IDLE;
        rd_addr_d = '0;
        if (bus.start) begin
          state_d    = S_HDR_SYNC;
          baud_d     = '0;
          bit_d      = '0;
          byte_cnt_d = '0;
          tx_byte_d  = SYNC_BYTE;
`ifdef UART_FRAME_CHECKSUM_EN
          csum_d     = '0;
`endif
        end
      end
      default: begin
        if (bit_end_c) begin
          baud_d = '0;
          bit_d  = bit_q + 4'd1;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
        if (byte_end_c) begin
          bit_d = '0;
          case (state_q)
            S_HDR_SYNC: begin
              state_d   = S_HDR_LEN_HI;
              tx_byte_d = LEN16[15:8];
            end
            S_HDR_LEN_HI: begin
              state_d   = S_HDR_LEN_LO;
              tx_byte_d = LEN16[7:0];
            end
            S_HDR_LEN_LO: begin
              state_d    = S_PAYLOAD;
              tx_byte_d  = bus.rd_data;
              byte_cnt_d = '0;
              rd_addr_d  = ADDR_W'(1);
`ifdef UART_FRAME_CHECKSUM_EN
              csum_d     = csum_q + bus.rd_data;
`endif
            end
            S_PAYLOAD: begin
              if (byte_cnt_q == CNT_LAST) begin
                rd_addr_d = '0;
`ifdef UART_FRAME_CHECKSUM_EN
                state_d   = S_CHECKSUM;
                tx_byte_d = csum_q;
`else
                state_d   = S_DONE;
`endif
              end else begin
                // Address runs one byte ahead so rd_data is settled at the load edge.
                byte_cnt_d = byte_cnt_q + 16'd1;
                tx_byte_d  = bus.rd_data;
                rd_addr_d  = ADDR_W'(byte_cnt_q + 16'd2);
`ifdef UART_FRAME_CHECKSUM_EN
                csum_d     = csum_q + bus.rd_data;
`endif
              end
            end
`ifdef UART_FRAME_CHECKSUM_EN
            S_CHECKSUM: state_d = S_DONE;
`endif
            default: state_d = S_IDLE;
          endcase
        end
      end
    endcase

    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
    if (busy_d) begin
      if (bit_d == 4'd0) begin
        tx_d = 1'b0;
      end else if (bit_d == STOP_BIT) begin
        tx_d = 1'b1;
      end else begin
        tx_d = tx_byte_d[3'(bit_d - 4'd1)];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      byte_cnt_q <= '0;
      tx_byte_q  <= '0;
      rd_addr_q  <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      byte_cnt_q <= byte_cnt_d;
      tx_byte_q  <= tx_byte_d;
      rd_addr_q  <= rd_addr_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef UART_FRAME_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign bus.tx      = tx_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rd_addr = rd_addr_q;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Bench for uart_frame_tx: table vectors, random payloads, and hand-written reset/timing sequences.
module tb_uart_frame_tx;

  localparam int unsigned CPB   = 4;
  localparam int unsigned CPB2  = 2;
  localparam int unsigned FL    = 4;
  localparam int unsigned AW    = 2;
  localparam int unsigned BYTE_T = 10 * CPB;
`ifdef UART_FRAME_CHECKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_frame_tx_if #(.ADDR_W(AW)) bus ();
  uart_frame_tx_if #(.ADDR_W(AW)) bus2 ();

  uart_frame_tx #(.CLKS_PER_BIT(CPB), .FRAME_LEN(FL), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  uart_frame_tx #(.CLKS_PER_BIT(CPB2), .FRAME_LEN(FL), .ADDR_W(AW)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  assign bus2.start   = bus.start;
  assign bus2.rd_data = 8'h00;

  // Synchronous buffer: one cycle from rd_addr to rd_data.
  logic [7:0] mem [4];
  always @(posedge clk) bus.rd_data <= mem[bus.rd_addr];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference frame as a plain byte list.
  logic [7:0] frame_q[$];

  task automatic make_frame(input logic [31:0] pl, input logic [7:0] ck);
    frame_q = {};
    frame_q.push_back(8'hA5);
    frame_q.push_back(8'(FL >> 8));
    frame_q.push_back(8'(FL & 32'hFF));
    for (int i = 0; i < 4; i++) begin
      frame_q.push_back(pl[8*i +: 8]);
      mem[i] = pl[8*i +: 8];
    end
    if (CK_EN) frame_q.push_back(ck);
  endtask

  function automatic logic exp_tx(input int c);
    int j;
    int b;
    logic [7:0] bv;
    j  = c / BYTE_T;
    b  = (c % BYTE_T) / CPB;
    bv = frame_q[j];
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return bv[b-1];
  endfunction

  function automatic logic [AW-1:0] exp_addr(input int c);
    int k;
    k = c / BYTE_T - 3;
    if (k >= 0 && k < int'(FL)) return AW'((k + 1) % (1 << AW));
    return '0;
  endfunction

  function automatic logic [7:0] sum_bytes(input logic [31:0] pl);
    logic [7:0] s;
    s = 8'h00;
    for (int i = 0; i < 4; i++) s = s + pl[8*i +: 8];
    return s;
  endfunction

  logic bit_pat [10];

  // One full frame, optionally already started by the previous done cycle.
  task automatic run_frame(input logic [31:0] pl, input logic [7:0] ck, input bit pre,
                           input bit mid, input bit chain, input bit chk2, input string tag);
    int len;
    int e_tx;
    int e_busy;
    int e_addr;
    int busy_cnt;
    e_tx = 0; e_busy = 0; e_addr = 0; busy_cnt = 0;
    make_frame(pl, ck);
    len = frame_q.size() * BYTE_T;
    if (!pre) begin
      @(negedge clk);
      bus.start = 1'b1;
    end
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      if (bus.tx !== exp_tx(c)) e_tx++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) e_busy++;
      if (bus.rd_addr !== exp_addr(c)) e_addr++;
      if (bus.busy === 1'b1) busy_cnt++;
      if (chk2 && c < 20) check($sformatf("%s_bit_timing_c%0d", tag, c), 32'(bus2.tx), 32'(bit_pat[c/2]));
      bus.start = mid && (c == 10 || c == 100);
    end
    check($sformatf("%s_tx_errcycles", tag), e_tx, 0);
    check($sformatf("%s_busy_errcycles", tag), e_busy, 0);
    check($sformatf("%s_addr_errcycles", tag), e_addr, 0);
    check($sformatf("%s_busy_len", tag), busy_cnt, len);
    @(negedge clk);
    check($sformatf("%s_done_pulse", tag), {bus.done, bus.busy, bus.tx}, 3'b101);
    check($sformatf("%s_done_addr", tag), 32'(bus.rd_addr), 0);
    bus.start = chain;
    if (!chain) begin
      @(negedge clk);
      check($sformatf("%s_after_done", tag), {bus.done, bus.busy, bus.tx}, 3'b001);
    end
  endtask

  typedef struct {
    logic [31:0] pl;
    logic [7:0]  ck;
    bit          mid;
    bit          chain;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int idle_bad;
    bit prev;
    logic [31:0] pl;
    bit ch;

    bit_pat = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[0] = '{32'hF0302010, 8'h50, 1'b0, 1'b0};
    vecs[1] = '{32'h04030201, 8'h0A, 1'b1, 1'b0};
    vecs[2] = '{32'h000001FF, 8'h00, 1'b0, 1'b1};
    vecs[3] = '{32'h80808080, 8'h00, 1'b0, 1'b0};

    for (int i = 0; i < 4; i++) mem[i] = 8'h00;
    rst = 1'b1;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {bus.tx, bus.busy, bus.done}, 3'b100);
    check("reset_addr", 32'(bus.rd_addr), 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", {bus.tx, bus.busy, bus.done}, 3'b100);

    prev = 1'b0;
    for (int i = 0; i < 4; i++) begin
      run_frame(vecs[i].pl, vecs[i].ck, prev, vecs[i].mid, vecs[i].chain, i == 0, $sformatf("vec%0d", i));
      prev = vecs[i].chain;
    end

    // Reset in the middle of payload[1], with start asserted alongside rst.
    make_frame(32'hDDCCBBAA, 8'h00);
    @(negedge clk);
    bus.start = 1'b1;
    for (int c = 0; c < int'(4 * BYTE_T + 15); c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    check("midrst_outputs", {bus.tx, bus.busy, bus.done}, 3'b100);
    check("midrst_addr", 32'(bus.rd_addr), 0);
    rst = 1'b0;
    bus.start = 1'b0;
    idle_bad = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.tx !== 1'b1) idle_bad++;
    end
    check("midrst_no_done_no_busy", idle_bad, 0);
    run_frame(32'hDDCCBBAA, sum_bytes(32'hDDCCBBAA), 1'b0, 1'b0, 1'b0, 1'b0, "after_rst");

    prev = 1'b0;
    for (int r = 0; r < 6; r++) begin
      pl = $urandom;
      ch = (r < 5) ? 1'($urandom_range(0, 1)) : 1'b0;
      run_frame(pl, sum_bytes(pl), prev, 1'($urandom_range(0, 1)), ch, 1'b0, $sformatf("rnd%0d", r));
      prev = ch;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
